approx_add_arbiter: RTL
=======================

# approx_add_arbiter

Shares one runtime-configurable 6-bit approximate adder datapath between NREQ requesters. Round-robin arbitration with per-requester valid/ready handshakes, one registered result slot with an id tag, and per-operation selection between exact and approximate addition. Sits between the accelerator's operand producers and the shared add resource; the only block that drives the approximate-adder datapath.

## Interface
- NREQ, 4: number of requesters (2..8); ID_W = clog2(NREQ).
- APPROX_BITS, 5: number of approximated LSBs used when an operation requests approximate mode (1..6).

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted (one-hot or zero).
- req_a  in  NREQ*6  operand A, requester i at [6i+5:6i].
- req_b  in  NREQ*6  operand B, same packing.
- req_approx  in  NREQ  1 = approximate (k = APPROX_BITS), 0 = exact (k = 0).
- rsp_valid  out  1  result slot full.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  7  sum; bit 6 = carry-out.
- rsp_id  out  ID_W  requester index of the result.
- rsp_approx  out  1  mode used for the result.
- err_clr  in  1  (APPROX_ERR_MON_EN only) synchronous clear of the monitors.
- err_acc  out  16  (APPROX_ERR_MON_EN only) saturating sum of |exact − approx|.
- approx_ops  out  16  (APPROX_ERR_MON_EN only) saturating count of approximate operations.

## Operation
- Adder rule for level k: Y[i] = A[i] | B[i] for i < k; carry into bit k = A[k−1] & B[k−1] (k > 0), 0 (k = 0); bits k..5 exact ripple-carry with G = A&B, P = A|B; Y[6] = final carry.
- Output slot FSM: EMPTY, FULL. EMPTY→FULL on accept; FULL→EMPTY on rsp_ready without accept; FULL→FULL on rsp_ready with accept (back-to-back).
- can_accept = EMPTY or (FULL and rsp_ready).
- Arbiter: when can_accept, grant the first requester with req_valid, searching from pointer rr upward with wrap. req_ready[g] = 1 for that requester only; req_ready is combinational from req_valid, rr, slot state, rsp_ready.
- On accept of g: latch the sum of req_a[g], req_b[g] at level k into rsp_sum, g into rsp_id, req_approx[g] into rsp_approx; rr ← (g+1) mod NREQ. No accept → rr unchanged.
- Requesters must hold operands stable while req_valid is high and req_ready is low; deasserting before accept is allowed (request dropped, no side effects).
- While FULL and not rsp_ready: rsp_* held stable, all req_ready = 0.

## Timing
- Reset values: rsp_valid 0, rsp_sum 0, rsp_id 0, rsp_approx 0, rr 0, state EMPTY, err_acc 0, approx_ops 0. req_ready is 0 during reset.
- Latency: accept in cycle n → rsp_valid at cycle n+1 with result. Throughput 1 op/cycle with rsp_ready held high.
- Reset asserted mid-operation: pending result discarded, all state returns to reset values asynchronously; first grant after release goes to requester 0 if valid.

## Configuration
- APPROX_ERR_MON_EN defined: on each accept with req_approx = 1, approx_ops += 1 and err_acc += |exact sum − approximate sum|, both saturating at 16'hFFFF. Exact-mode accepts do not change them. err_clr zeroes both next cycle; if err_clr coincides with an accept, the clear wins and that update is dropped.
- Undefined: err_clr, err_acc, approx_ops ports and the exact reference adder are absent; behaviour otherwise identical.

## Structure
- Package approx_ctrl_pkg: OPW = 6, SUMW = 7, slot-state enum (EMPTY, FULL), 16-bit saturating-counter width constant.
- Sub-module approx_add_core: combinational, inputs a[5:0], b[5:0], k[2:0], output y[6:0], implementing the adder rule above for any k in 0..6. Instantiated once for the shared path; a second instance with k = 0 serves as the exact reference under APPROX_ERR_MON_EN.

## Test plan
- Requester 0, A=31, B=1, approx=0 → one cycle later rsp_sum=32, rsp_id=0, rsp_approx=0; same with approx=1, APPROX_BITS=5 → rsp_sum=31.
- A=63, B=63, approx=1, APPROX_BITS=5 → rsp_sum=127; exact → 126.
- All four requesters valid continuously, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later.
- rsp_ready=0 for 3 cycles with slot FULL → rsp_* stable, req_ready=0; rsp_ready rises → next requester accepted the same cycle, new result the following cycle.
- rst_n pulsed low while FULL → rsp_valid=0 immediately, rr=0, later grant to requester 0.
- APPROX_ERR_MON_EN: the two approximate ops above → approx_ops=2, err_acc=2; err_clr coinciding with a third accept → both 0; preload to saturation → hold at 16'hFFFF.

Source files
------------

// File: rtl/approx_add_arbiter_pkg.sv
// Shared constants, slot-state enum and saturating-add helper for the approximate adder arbiter.
package approx_ctrl_pkg;

  localparam int OPW  = 6;
  localparam int SUMW = 7;
  localparam int CNTW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [CNTW-1:0] b);
    logic [CNTW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
  endfunction

endpackage

// File: rtl/approx_add_arbiter_if.sv
// Request/response bundle between the operand producers, the arbiter and the result consumer.
interface approx_add_arbiter_if #(parameter int NREQ = 4);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                     req_valid;
  logic [NREQ-1:0]                     req_ready;
  logic [NREQ*approx_ctrl_pkg::OPW-1:0] req_a;
  logic [NREQ*approx_ctrl_pkg::OPW-1:0] req_b;
  logic [NREQ-1:0]                     req_approx;
  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [approx_ctrl_pkg::SUMW-1:0]    rsp_sum;
  logic [ID_W-1:0]                     rsp_id;
  logic                                rsp_approx;

  modport master (
    output req_valid, req_a, req_b, req_approx, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_approx
  );

  modport slave (
    input  req_valid, req_a, req_b, req_approx, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_approx
  );

endinterface

// File: rtl/approx_add_arbiter_core.sv
// Combinational 6-bit approximate adder: the k LSBs are OR-ed, the rest ripple exactly.
module approx_add_core
  import approx_ctrl_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [2:0]      k,
  output logic [SUMW-1:0] y
);

  logic c;

  always_comb begin
    y = '0;
    c = 1'b0;
    for (int i = 0; i < OPW; i++) begin
      if (i < int'(k)) begin
        y[i] = a[i] | b[i];
        // The last approximated bit's generate becomes the carry into bit k.
        c    = a[i] & b[i];
      end else begin
        y[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | ((a[i] | b[i]) & c);
      end
    end
    y[OPW] = c;
  end

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one approximate adder among NREQ requesters with a one-deep result slot.
// Define APPROX_ERR_MON_EN to add the approximation-error and op-count monitors.
module approx_add_arbiter
  import approx_ctrl_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int APPROX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_add_arbiter_if.slave bus
`ifdef APPROX_ERR_MON_EN
  ,
  input  logic                err_clr,
  output logic [CNTW-1:0]     err_acc,
  output logic [CNTW-1:0]     approx_ops
`endif
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  slot_e            state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [SUMW-1:0]  rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_approx_q, rsp_approx_d;

  logic             can_accept, gnt_vld, accept;
  logic [ID_W-1:0]  gnt_id;
  int               idx;
  logic [OPW-1:0]   op_a, op_b;
  logic             op_approx;
  logic [2:0]       k_lvl;
  logic [SUMW-1:0]  sum_apx;

  // Grant search starts at rr and wraps; reset gates readiness so nothing is accepted while held.
  always_comb begin
    can_accept = rst_n && ((state_q == EMPTY) || bus.rsp_ready);
    gnt_vld    = 1'b0;
    gnt_id     = '0;
    idx        = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(rr_q) + off) % NREQ;
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    accept = can_accept && gnt_vld;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      bus.req_ready[i] = accept && (gnt_id == ID_W'(i));
  end

  always_comb begin
    op_a      = bus.req_a[int'(gnt_id)*OPW +: OPW];
    op_b      = bus.req_b[int'(gnt_id)*OPW +: OPW];
    op_approx = bus.req_approx[gnt_id];
    k_lvl     = op_approx ? 3'(APPROX_BITS) : 3'd0;
  end

  approx_add_core u_core (
    .a (op_a),
    .b (op_b),
    .k (k_lvl),
    .y (sum_apx)
  );

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;
    rsp_approx_d = rsp_approx_q;
    if (accept) begin
      state_d      = FULL;
      rsp_sum_d    = sum_apx;
      rsp_id_d     = gnt_id;
      rsp_approx_d = op_approx;
      rr_d         = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      rr_q         <= '0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= '0;
      rsp_approx_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
      rsp_approx_q <= rsp_approx_d;
    end
  end

  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_approx = rsp_approx_q;

`ifdef APPROX_ERR_MON_EN
  logic [SUMW-1:0] sum_exact, err_abs;
  logic [CNTW-1:0] err_acc_q, err_acc_d, approx_ops_q, approx_ops_d;

  approx_add_core u_ref (
    .a (op_a),
    .b (op_b),
    .k (3'd0),
    .y (sum_exact)
  );

  // Clear has priority over a coinciding update.
  always_comb begin
    err_abs      = (sum_exact >= sum_apx) ? (sum_exact - sum_apx) : (sum_apx - sum_exact);
    err_acc_d    = err_acc_q;
    approx_ops_d = approx_ops_q;
    if (err_clr) begin
      err_acc_d    = '0;
      approx_ops_d = '0;
    end else if (accept && op_approx) begin
      err_acc_d    = sat_add(err_acc_q, CNTW'(err_abs));
      approx_ops_d = sat_add(approx_ops_q, CNTW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc_q    <= '0;
      approx_ops_q <= '0;
    end else begin
      err_acc_q    <= err_acc_d;
      approx_ops_q <= approx_ops_d;
    end
  end

  assign err_acc    = err_acc_q;
  assign approx_ops = approx_ops_q;
`endif

endmodule
